line_store_responder: RTL and testbench

- Responder side of the line read/write interface driven by the hash controller.
- Holds an input bank of 2^ADDR_W lines, preloaded by the host or bench.
- Serves line read requests with a fixed, parameterised latency.
- Accepts write-back lines into a separate output bank, counts them, and flags when a full file has been written back.

---
 rtl/line_store_responder.sv | 185 ++++++++++++++++++
 tb/tb_line_store_responder.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_store_responder.sv
// line_store_responder: responder for the hash controller's line read and
// write-back interface.
//   - Input bank of 2^ADDR_W lines, filled through the load port.
//   - Reads return the captured line RD_LAT cycles after acceptance.
//   - Write-backs go to a separate output bank, are acknowledged one cycle
//     later, and are counted. The count saturates at 2^ADDR_W, and a sticky
//     flag marks a fully written file.
// Optional feature macro: LINE_STORE_PARITY_EN. When defined, an even-parity
// bit is stored per input line and checked on read (rd_perr). When it is
// undefined, rd_perr is tied low.
//
// Read handshake: a request is accepted when rd_req=1 while busy=0 and
// clear=0. The line at line_index is captured on that clock edge. rd_valid
// then pulses for exactly one cycle, RD_LAT cycles after acceptance, with
// rd_data holding the captured line. rd_req seen while busy=1 is dropped and
// is not queued.
module line_store_responder #(
    parameter int LINE_W = 25,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LINE_W-1:0] load_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] line_index,
    output logic [LINE_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_index,
    input  logic [LINE_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W:0]   wr_count,
    output logic              all_written,
    output logic              rd_perr
);

    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [2:0]      LAT_LOAD   = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Read FSM state. It is visible hierarchically to checkers as dut.state.
    state_t            state;
    state_t            state_next;
    logic              accept;
    logic [2:0]        lat_cnt;
    logic [LINE_W-1:0] in_mem  [DEPTH];
    logic [LINE_W-1:0] out_mem [DEPTH];

    // Input bank preload. The contents survive both reset and clear.
    always_ff @(posedge clk) begin
        if (load_en) begin
            in_mem[load_addr] <= load_data;
        end
    end

    // Output bank write-back. A write that coincides with clear is discarded.
    always_ff @(posedge clk) begin
        if (wr_req && !clear) begin
            out_mem[wr_index] <= wr_data;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM next state and outputs.
    // WAIT lasts RD_LAT-1 cycles and is followed by one RESP cycle, so
    // rd_valid lands exactly RD_LAT cycles after acceptance. The counter is
    // loaded with RD_LAT-1, and WAIT exits on the cycle where the decrement
    // reaches zero. With RD_LAT=1 the FSM goes straight from IDLE to RESP.
    // clear forces IDLE and masks this cycle's busy and rd_valid.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        rd_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_req) begin
                    accept     = 1'b1;
                    state_next = (RD_LAT == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (lat_cnt <= 3'd1) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                busy       = 1'b1;
                rd_valid   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_next = ST_IDLE;
            accept     = 1'b0;
            busy       = 1'b0;
            rd_valid   = 1'b0;
        end
    end

    // Latency counter and response capture. The line is taken at acceptance,
    // so later loads to the same address do not affect this response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt <= '0;
            rd_data <= '0;
        end else if (accept) begin
            lat_cnt <= LAT_LOAD;
            rd_data <= in_mem[line_index];
        end else if (state == ST_WAIT) begin
            lat_cnt <= lat_cnt - 3'd1;
        end
    end

    // Write acknowledge, saturating write-back count and sticky full flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ack      <= 1'b0;
            wr_count    <= '0;
            all_written <= 1'b0;
        end else if (clear) begin
            wr_ack      <= 1'b0;
            wr_count    <= '0;
            all_written <= 1'b0;
        end else begin
            wr_ack <= wr_req;
            if (wr_req && (wr_count != FULL_COUNT)) begin
                wr_count <= wr_count + COUNT_ONE;
                if (wr_count + COUNT_ONE == FULL_COUNT) begin
                    all_written <= 1'b1;
                end
            end
        end
    end

`ifdef LINE_STORE_PARITY_EN
    logic [DEPTH-1:0] par_bits;
    logic             resp_par;

    // Store the even-parity bit of each line as it is loaded.
    always_ff @(posedge clk) begin
        if (load_en) begin
            par_bits[load_addr] <= ^load_data;
        end
    end

    // Capture the stored parity bit together with the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_par <= 1'b0;
        end else if (accept) begin
            resp_par <= par_bits[line_index];
        end
    end

    assign rd_perr = rd_valid && ((^rd_data) != resp_par);
`else
    assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_line_store_responder.sv
// Self-checking bench for line_store_responder. The reference model tracks
// the input and output banks as arrays. In-flight reads are modelled as
// windows of cycles after acceptance, with an expected-data queue.
module tb_line_store_responder;

    localparam int LINE_W = 25;
    localparam int ADDR_W = 6;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [LINE_W-1:0] load_data = '0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] line_index = '0;
    logic [LINE_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_index = '0;
    logic [LINE_W-1:0] wr_data = '0;
    logic              wr_ack;
    logic [ADDR_W:0]   wr_count;
    logic              all_written;
    logic              rd_perr;

    int checks = 0;
    int failures = 0;

    logic [LINE_W-1:0] ref_in  [DEPTH];
    logic [LINE_W-1:0] ref_out [DEPTH];
    logic [LINE_W-1:0] exp_q[$];

    line_store_responder #(
        .LINE_W(LINE_W),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .rd_req(rd_req),
        .line_index(line_index),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .busy(busy),
        .wr_req(wr_req),
        .wr_index(wr_index),
        .wr_data(wr_data),
        .wr_ack(wr_ack),
        .wr_count(wr_count),
        .all_written(all_written),
        .rd_perr(rd_perr)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Driver: advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Driver: issue one read, with an optional load at a chosen cycle
    // offset, and observe the response window without judging it.
    task automatic drive_read(input logic [ADDR_W-1:0] idx, input int load_cycle,
                              input logic [ADDR_W-1:0] l_addr, input logic [LINE_W-1:0] l_data,
                              output int lat, output int nresp, output int busy_cycles,
                              output logic [LINE_W-1:0] data, output logic perr);
        lat = -1;
        nresp = 0;
        busy_cycles = 0;
        data = '0;
        perr = 1'b0;
        for (int c = 0; c <= RD_LAT + 3; c++) begin
            rd_req = (c == 0);
            line_index = idx;
            load_en = (c == load_cycle);
            load_addr = l_addr;
            load_data = l_data;
            @(negedge clk);
            if (busy) busy_cycles++;
            if (rd_valid) begin
                nresp++;
                if (lat < 0) begin
                    lat = c;
                    data = rd_data;
                    perr = rd_perr;
                end
            end
            next_cycle();
        end
        rd_req = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #2;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL reset_wr_ack: got %0b expected 0", wr_ack); end
        checks++; if (wr_count !== '0) begin failures++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count); end
        checks++; if (all_written !== 1'b0) begin failures++; $display("FAIL reset_all_written: got %0b expected 0", all_written); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
        checks++; if (rd_perr !== 1'b0) begin failures++; $display("FAIL reset_rd_perr: got %0b expected 0", rd_perr); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_load_and_read();
        int idxs[3] = '{0, 17, 63};
        int lat, nresp, bc;
        logic [LINE_W-1:0] d;
        logic p;
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1'b1;
            load_addr = ADDR_W'(i);
            load_data = LINE_W'(i * 3 + 1);
            ref_in[i] = LINE_W'(i * 3 + 1);
            next_cycle();
        end
        load_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_read(ADDR_W'(idxs[k]), -1, '0, '0, lat, nresp, bc, d, p);
            checks++; if (lat !== RD_LAT) begin failures++; $display("FAIL read_latency idx %0d: got %0d expected %0d", idxs[k], lat, RD_LAT); end
            checks++; if (d !== ref_in[idxs[k]]) begin failures++; $display("FAIL read_data idx %0d: got %0h expected %0h", idxs[k], d, ref_in[idxs[k]]); end
            checks++; if (bc !== RD_LAT) begin failures++; $display("FAIL read_busy_cycles idx %0d: got %0d expected %0d", idxs[k], bc, RD_LAT); end
            checks++; if (nresp !== 1) begin failures++; $display("FAIL read_responses idx %0d: got %0d expected 1", idxs[k], nresp); end
        end
    endtask

    // rd_req held across three full request periods: acceptance every
    // RD_LAT+1 cycles, and requests seen while busy are dropped.
    task automatic test_hold_req();
        int nresp = 0;
        bit exp_v;
        for (int c = 0; c <= 12; c++) begin
            rd_req = (c < 9);
            line_index = 7;
            @(negedge clk);
            exp_v = (c == 2) || (c == 5) || (c == 8);
            checks++; if (rd_valid !== exp_v) begin failures++; $display("FAIL hold_rd_valid cycle %0d: got %0b expected %0b", c, rd_valid, exp_v); end
            if (rd_valid) begin
                nresp++;
                checks++; if (rd_data !== ref_in[7]) begin failures++; $display("FAIL hold_rd_data cycle %0d: got %0h expected %0h", c, rd_data, ref_in[7]); end
            end
            next_cycle();
        end
        rd_req = 1'b0;
        checks++; if (nresp !== 3) begin failures++; $display("FAIL hold_response_count: got %0d expected 3", nresp); end
    endtask

    task automatic test_load_during_read();
        int lat, nresp, bc;
        logic [LINE_W-1:0] d, old;
        logic p;
        // Load on the cycle after the request: the response keeps the old line.
        old = ref_in[5];
        drive_read(6'd5, 1, 6'd5, 25'h1ABCDEF, lat, nresp, bc, d, p);
        ref_in[5] = 25'h1ABCDEF;
        checks++; if (d !== old || lat !== RD_LAT) begin failures++; $display("FAIL load_in_flight: got %0h@%0d expected %0h@%0d", d, lat, old, RD_LAT); end
        drive_read(6'd5, -1, '0, '0, lat, nresp, bc, d, p);
        checks++; if (d !== ref_in[5]) begin failures++; $display("FAIL load_in_flight_after: got %0h expected %0h", d, ref_in[5]); end
        // Load in the same cycle as the request: old line, new contents afterwards.
        old = ref_in[6];
        drive_read(6'd6, 0, 6'd6, 25'h0F0F0F0, lat, nresp, bc, d, p);
        ref_in[6] = 25'h0F0F0F0;
        checks++; if (d !== old) begin failures++; $display("FAIL load_same_cycle: got %0h expected %0h", d, old); end
        drive_read(6'd6, -1, '0, '0, lat, nresp, bc, d, p);
        checks++; if (d !== ref_in[6]) begin failures++; $display("FAIL load_same_cycle_after: got %0h expected %0h", d, ref_in[6]); end
    endtask

    // Random requests and loads. A read accepted in cycle a keeps the
    // responder busy in cycles a+1..a+RD_LAT and responds in cycle a+RD_LAT.
    task automatic test_random_reads();
        bit have = 0;
        int acc = 0, resp = 0;
        bit req, ld, busy_exp, valid_exp;
        logic [ADDR_W-1:0] idx, la;
        logic [LINE_W-1:0] ldat, e;
        exp_q.delete();
        for (int c = 0; c < 300; c++) begin
            req = (c < 290) ? 1'($urandom_range(0, 1)) : 1'b0;
            idx = ADDR_W'($urandom_range(0, DEPTH - 1));
            ld = ($urandom_range(0, 3) == 0);
            la = ADDR_W'($urandom_range(0, DEPTH - 1));
            ldat = LINE_W'($urandom);
            rd_req = req;
            line_index = idx;
            load_en = ld;
            load_addr = la;
            load_data = ldat;
            busy_exp = have && (c > acc) && (c <= resp);
            valid_exp = have && (c == resp);
            if (req && !busy_exp) begin
                have = 1;
                acc = c;
                resp = c + RD_LAT;
                exp_q.push_back(ref_in[idx]);
            end
            if (ld) ref_in[la] = ldat;
            @(negedge clk);
            checks++; if (busy !== busy_exp) begin failures++; $display("FAIL rand_busy cycle %0d: got %0b expected %0b", c, busy, busy_exp); end
            checks++; if (rd_valid !== valid_exp) begin failures++; $display("FAIL rand_rd_valid cycle %0d: got %0b expected %0b", c, rd_valid, valid_exp); end
            if (valid_exp && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if (rd_data !== e) begin failures++; $display("FAIL rand_rd_data cycle %0d: got %0h expected %0h", c, rd_data, e); end
                checks++; if (rd_perr !== 1'b0) begin failures++; $display("FAIL rand_rd_perr cycle %0d: got %0b expected 0", c, rd_perr); end
            end
            next_cycle();
        end
        rd_req = 1'b0;
        load_en = 1'b0;
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rand_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_write_path();
        int writes = 0;
        int ex;
        logic [LINE_W-1:0] d;
        int idx;
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        for (int c = 0; c <= 66; c++) begin
            wr_req = (c <= 64);
            wr_index = ADDR_W'(c % DEPTH);
            d = LINE_W'($urandom);
            wr_data = d;
            @(negedge clk);
            ex = (writes > DEPTH) ? DEPTH : writes;
            checks++; if (wr_ack !== (c >= 1 && c <= 65)) begin failures++; $display("FAIL wr_ack cycle %0d: got %0b expected %0b", c, wr_ack, (c >= 1 && c <= 65)); end
            checks++; if (wr_count !== (ADDR_W + 1)'(ex)) begin failures++; $display("FAIL wr_count cycle %0d: got %0d expected %0d", c, wr_count, ex); end
            checks++; if (all_written !== (ex == DEPTH)) begin failures++; $display("FAIL all_written cycle %0d: got %0b expected %0b", c, all_written, (ex == DEPTH)); end
            if (wr_req) begin
                writes++;
                ref_out[c % DEPTH] = d;
            end
            next_cycle();
        end
        wr_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(0, DEPTH - 1);
            checks++; if (dut.out_mem[idx] !== ref_out[idx]) begin failures++; $display("FAIL out_bank idx %0d: got %0h expected %0h", idx, dut.out_mem[idx], ref_out[idx]); end
        end
    endtask

    task automatic test_clear();
        int lat, nresp, bc;
        logic [LINE_W-1:0] d;
        logic p;
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        @(negedge clk);
        checks++; if (all_written !== 1'b0 || wr_count !== '0) begin failures++; $display("FAIL clear_counts: got %0d/%0b expected 0/0", wr_count, all_written); end
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            wr_req = 1'b1;
            wr_index = ADDR_W'(20 + i);
            wr_data = LINE_W'($urandom);
            ref_out[20 + i] = wr_data;
            next_cycle();
        end
        wr_req = 1'b0;
        @(negedge clk);
        checks++; if (wr_count !== 7'd10) begin failures++; $display("FAIL clear_pre_count: got %0d expected 10", wr_count); end
        next_cycle();
        // Start a read, then clear while it waits; the write and read die.
        rd_req = 1'b1;
        line_index = 3;
        next_cycle();
        rd_req = 1'b0;
        clear = 1'b1;
        wr_req = 1'b1;
        wr_index = 40;
        wr_data = ~ref_out[40];
        load_en = 1'b1;
        load_addr = 11;
        load_data = 25'h1234567;
        ref_in[11] = 25'h1234567;
        next_cycle();
        clear = 1'b0;
        wr_req = 1'b0;
        load_en = 1'b0;
        @(negedge clk);
        checks++; if (wr_count !== '0) begin failures++; $display("FAIL clear_wr_count: got %0d expected 0", wr_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_busy: got %0b expected 0", busy); end
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL clear_wr_ack: got %0b expected 0", wr_ack); end
        checks++; if (all_written !== 1'b0) begin failures++; $display("FAIL clear_all_written: got %0b expected 0", all_written); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL clear_no_response cycle %0d: got %0b expected 0", k, rd_valid); end
            next_cycle();
            @(negedge clk);
        end
        next_cycle();
        checks++; if (dut.out_mem[40] !== ref_out[40]) begin failures++; $display("FAIL clear_discard_write: got %0h expected %0h", dut.out_mem[40], ref_out[40]); end
        drive_read(6'd11, -1, '0, '0, lat, nresp, bc, d, p);
        checks++; if (d !== ref_in[11] || lat !== RD_LAT) begin failures++; $display("FAIL clear_load_kept: got %0h@%0d expected %0h@%0d", d, lat, ref_in[11], RD_LAT); end
    endtask

    task automatic test_reset_abort();
        int nresp = 0;
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1;
            wr_index = ADDR_W'(i);
            wr_data = ref_out[i];
            next_cycle();
        end
        wr_req = 1'b0;
        rd_req = 1'b1;
        line_index = 2;
        next_cycle();
        rd_req = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin failures++; $display("FAIL abort_immediate: got busy %0b valid %0b expected 0 0", busy, rd_valid); end
        checks++; if (wr_count !== '0) begin failures++; $display("FAIL abort_wr_count: got %0d expected 0", wr_count); end
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rd_valid) nresp++;
            next_cycle();
        end
        checks++; if (nresp !== 0) begin failures++; $display("FAIL abort_no_response: got %0d expected 0", nresp); end
    endtask

`ifdef LINE_STORE_PARITY_EN
    task automatic test_parity();
        int lat, nresp, bc;
        logic [LINE_W-1:0] d;
        logic p;
        logic bad;
        bad = ~(^ref_in[9]);
        force dut.par_bits[9] = bad;
        drive_read(6'd9, -1, '0, '0, lat, nresp, bc, d, p);
        checks++; if (p !== 1'b1 || lat !== RD_LAT) begin failures++; $display("FAIL parity_bad: got %0b@%0d expected 1@%0d", p, lat, RD_LAT); end
        release dut.par_bits[9];
        drive_read(6'd8, -1, '0, '0, lat, nresp, bc, d, p);
        checks++; if (p !== 1'b0 || lat !== RD_LAT) begin failures++; $display("FAIL parity_good: got %0b@%0d expected 0@%0d", p, lat, RD_LAT); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_and_read();
        test_hold_req();
        test_load_during_read();
        test_random_reads();
        test_write_path();
        test_clear();
        test_reset_abort();
`ifdef LINE_STORE_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
